hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller. It generates the per-stage enables, bubbles, flushes and forwarding selects consumed by the F/D, D/E and E/M pipeline registers.
- Sequences the multi-cycle divider, which stalls the whole pipeline while a divide sits in Execute.
- Resolves load-use hazards, taken-branch/jump flushes and RAW forwarding for the 5-stage RV32 core.

---
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side stage info in, per-stage controls out.
// master = pipeline/datapath side, slave = hazard_ctrl.
// Pure wiring, no state.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
);
  // Decode / Execute / Memory / Writeback stage information
  logic [REG_ADDR_W-1:0] D_ra;
  logic [REG_ADDR_W-1:0] D_rb;
  logic [REG_ADDR_W-1:0] E_ra;
  logic [REG_ADDR_W-1:0] E_rb;
  logic [REG_ADDR_W-1:0] E_rd;
  logic                  E_RegWrite;
  logic [1:0]            E_result_src;
  logic                  E_is_div;
  logic                  E_PCSrc;
  logic [REG_ADDR_W-1:0] M_rd;
  logic [REG_ADDR_W-1:0] W_rd;
  logic                  M_RegWrite;
  logic                  W_RegWrite;
  logic                  div_done;

  // Pipeline register controls and status
  logic              F_en;
  logic              F_D_en;
  logic              F_D_flush;
  logic              D_E_en;
  logic              no_op;
  logic              CTRL_Flush;
  logic              E_M_en;
  logic [1:0]        fwdA;
  logic [1:0]        fwdB;
  logic              div_start;
  logic              div_busy;
  logic [PERF_W-1:0] stall_cycles;
  logic              div_timeout;

  modport master (
    output D_ra, D_rb, E_ra, E_rb, E_rd, E_RegWrite, E_result_src, E_is_div,
           E_PCSrc, M_rd, W_rd, M_RegWrite, W_RegWrite, div_done,
    input  F_en, F_D_en, F_D_flush, D_E_en, no_op, CTRL_Flush, E_M_en,
           fwdA, fwdB, div_start, div_busy, stall_cycles, div_timeout
  );

  modport slave (
    input  D_ra, D_rb, E_ra, E_rb, E_rd, E_RegWrite, E_result_src, E_is_div,
           E_PCSrc, M_rd, W_rd, M_RegWrite, W_RegWrite, div_done,
    output F_en, F_D_en, F_D_flush, D_E_en, no_op, CTRL_Flush, E_M_en,
           fwdA, fwdB, div_start, div_busy, stall_cycles, div_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects, load-use bubble, branch flush, divider sequencing.
// Latency: all controls combinational from current inputs and divider state; stall counter updates on clk.
// Backpressure: a divide in Execute holds every stage until div_done; HAZARD_DIV_TIMEOUT_EN adds a BUSY watchdog.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int DIV_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [REG_ADDR_W-1:0] REG_X0   = '0;
  localparam logic [1:0]            RES_LOAD = 2'b01;

  state_t            state_q, state_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              launch;
  logic              div_stall;
  logic              lw_hz;
  logic              timeout_hit;
  logic              timeout_flag;

  logic              f_en, fd_en, fd_flush, de_en, no_op, ctrl_flush, em_en;
  logic              div_start;
  logic [1:0]        fwd_a, fwd_b;

  // Divide ready to launch: a writing DIV in Execute that is not being squashed
  assign launch    = hz.E_is_div && hz.E_RegWrite && !hz.E_PCSrc;
  assign div_stall = ((state_q == S_IDLE) && launch) || (state_q == S_BUSY);

  // Load in Execute whose destination is a Decode source needs one bubble
  assign lw_hz = (hz.E_result_src == RES_LOAD) && hz.E_RegWrite && (hz.E_rd != REG_X0) &&
                 ((hz.E_rd == hz.D_ra) || (hz.E_rd == hz.D_rb));

`ifdef HAZARD_DIV_TIMEOUT_EN
  localparam int               CNT_W    = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Watchdog fires on the last allowed BUSY cycle unless the divider answers in that same cycle
  assign timeout_hit = (state_q == S_BUSY) && (cnt_q == CNT_LAST) && !hz.div_done;

  // BUSY-cycle counter next state: cleared on launch, counts while BUSY
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && launch) begin
      cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sticky timeout error, cleared only by reset
  assign timeout_d = timeout_q | timeout_hit;

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  // Without the watchdog BUSY waits for div_done indefinitely
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider next state; DONE ignores E_is_div since the same divide still sits in Execute
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_BUSY;
      S_BUSY:  if (hz.div_done || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage controls by priority: reset, divide stall, control transfer, load-use, normal flow
  always_comb begin
    f_en       = 1'b0;
    fd_en      = 1'b0;
    fd_flush   = 1'b0;
    de_en      = 1'b0;
    no_op      = 1'b0;
    ctrl_flush = 1'b0;
    em_en      = 1'b0;
    div_start  = 1'b0;
    if (!rst) begin
      div_start = (state_q == S_IDLE) && launch;
      if (div_stall) begin
        // whole front end holds; defaults already zero
      end else if (hz.E_PCSrc) begin
        f_en       = 1'b1;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        em_en      = 1'b1;
        fd_flush   = 1'b1;
        ctrl_flush = 1'b1;
      end else if (lw_hz) begin
        no_op = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
      end else begin
        f_en  = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
      end
    end
  end

  // Operand forwarding: Memory result beats Writeback result; x0 never forwards
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.M_RegWrite && (hz.M_rd != REG_X0) && (hz.M_rd == hz.E_ra)) begin
        fwd_a = 2'b10;
      end else if (hz.W_RegWrite && (hz.W_rd != REG_X0) && (hz.W_rd == hz.E_ra)) begin
        fwd_a = 2'b01;
      end
      if (hz.M_RegWrite && (hz.M_rd != REG_X0) && (hz.M_rd == hz.E_rb)) begin
        fwd_b = 2'b10;
      end else if (hz.W_RegWrite && (hz.W_rd != REG_X0) && (hz.W_rd == hz.E_rb)) begin
        fwd_b = 2'b01;
      end
    end
  end

  // Stall-cycle counter next state: counts cycles with the PC held, wrapping naturally
  assign stall_d = f_en ? stall_q : (stall_q + 1'b1);

  // Stall-cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.F_en         = f_en;
  assign hz.F_D_en       = fd_en;
  assign hz.F_D_flush    = fd_flush;
  assign hz.D_E_en       = de_en;
  assign hz.no_op        = no_op;
  assign hz.CTRL_Flush   = ctrl_flush;
  assign hz.E_M_en       = em_en;
  assign hz.fwdA         = fwd_a;
  assign hz.fwdB         = fwd_b;
  assign hz.div_start    = div_start;
  assign hz.div_busy     = (state_q != S_IDLE);
  assign hz.stall_cycles = stall_q;
  assign hz.div_timeout  = timeout_flag;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int DIV_TO = 8;
`ifdef HAZARD_DIV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        f_en, fd_en, fd_flush, de_en, no_op, ctrl_flush, em_en;
    logic [1:0]  fa, fb;
    logic        ds, db, to;
    logic [31:0] sc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  // reference model state: divide in flight, its one-cycle completion slot, elapsed busy cycles
  bit          m_in_flight;
  bit          m_finishing;
  int          m_elapsed;
  bit          m_to;
  logic [31:0] m_stalls;

  hazard_ctrl_if #(.REG_ADDR_W(5), .PERF_W(32)) hif ();

  hazard_ctrl #(.REG_ADDR_W(5), .DIV_TIMEOUT(DIV_TO), .PERF_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (hif.M_RegWrite && hif.M_rd != 5'd0 && hif.M_rd == src) return 2'b10;
    if (hif.W_RegWrite && hif.W_rd != 5'd0 && hif.W_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic zero_inputs();
    hif.D_ra = 0; hif.D_rb = 0; hif.E_ra = 0; hif.E_rb = 0; hif.E_rd = 0;
    hif.E_RegWrite = 0; hif.E_result_src = 0; hif.E_is_div = 0; hif.E_PCSrc = 0;
    hif.M_rd = 0; hif.W_rd = 0; hif.M_RegWrite = 0; hif.W_RegWrite = 0; hif.div_done = 0;
  endtask

  // Inputs for this cycle are already applied: predict outputs, queue them, advance model, step clock
  task automatic cycle();
    exp_t e;
    bit   lw, go, hold;
    e = '{default: '0};
    if (rst) begin
      m_in_flight = 0; m_finishing = 0; m_elapsed = 0; m_to = 0; m_stalls = 0;
    end else begin
      lw = (hif.E_result_src == 2'b01) && hif.E_RegWrite && hif.E_rd != 0 &&
           (hif.E_rd == hif.D_ra || hif.E_rd == hif.D_rb);
      go   = !m_in_flight && !m_finishing && hif.E_is_div && hif.E_RegWrite && !hif.E_PCSrc;
      hold = go || m_in_flight;
      if (hold) begin
        // everything already zero
      end else if (hif.E_PCSrc) begin
        e.f_en = 1; e.fd_en = 1; e.de_en = 1; e.em_en = 1; e.fd_flush = 1; e.ctrl_flush = 1;
      end else if (lw) begin
        e.no_op = 1; e.de_en = 1; e.em_en = 1;
      end else begin
        e.f_en = 1; e.fd_en = 1; e.de_en = 1; e.em_en = 1;
      end
      e.fa = fwd_of(hif.E_ra);
      e.fb = fwd_of(hif.E_rb);
      e.ds = go;
      e.db = m_in_flight || m_finishing;
      e.sc = m_stalls;
      e.to = m_to;
      if (!e.f_en) m_stalls = m_stalls + 1;
      if (go) begin
        m_in_flight = 1; m_elapsed = 0;
      end else if (m_in_flight) begin
        m_elapsed++;
        if (hif.div_done) begin
          m_in_flight = 0; m_finishing = 1;
        end else if (TO_EN && m_elapsed == DIV_TO) begin
          m_in_flight = 0; m_finishing = 1; m_to = 1;
        end
      end else begin
        m_finishing = 0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full control word
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("F_en", 32'(hif.F_en), 32'(e.f_en));
      chk("F_D_en", 32'(hif.F_D_en), 32'(e.fd_en));
      chk("F_D_flush", 32'(hif.F_D_flush), 32'(e.fd_flush));
      chk("D_E_en", 32'(hif.D_E_en), 32'(e.de_en));
      chk("no_op", 32'(hif.no_op), 32'(e.no_op));
      chk("CTRL_Flush", 32'(hif.CTRL_Flush), 32'(e.ctrl_flush));
      chk("E_M_en", 32'(hif.E_M_en), 32'(e.em_en));
      chk("fwdA", 32'(hif.fwdA), 32'(e.fa));
      chk("fwdB", 32'(hif.fwdB), 32'(e.fb));
      chk("div_start", 32'(hif.div_start), 32'(e.ds));
      chk("div_busy", 32'(hif.div_busy), 32'(e.db));
      chk("stall_cycles", hif.stall_cycles, e.sc);
      chk("div_timeout", 32'(hif.div_timeout), 32'(e.to));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // forwarding: M beats W, then W alone, then x0 never forwards
    hif.M_rd = 5; hif.M_RegWrite = 1; hif.W_rd = 5; hif.W_RegWrite = 1; hif.E_ra = 5; hif.E_rb = 5;
    cycle();
    hif.M_RegWrite = 0;
    cycle();
    hif.E_ra = 0; hif.E_rb = 0; hif.M_rd = 0; hif.W_rd = 0; hif.M_RegWrite = 1;
    cycle();
    zero_inputs();

    // load-use on D_rb: one bubble
    hif.E_result_src = 2'b01; hif.E_rd = 7; hif.E_RegWrite = 1; hif.D_rb = 7;
    cycle();
    zero_inputs();
    cycle();

    // branch wins over concurrent load-use
    hif.E_result_src = 2'b01; hif.E_rd = 7; hif.E_RegWrite = 1; hif.D_ra = 7; hif.E_PCSrc = 1;
    cycle();
    zero_inputs();

    // divide answered on the 10th BUSY cycle, then DONE and back to IDLE
    hif.E_is_div = 1; hif.E_RegWrite = 1; hif.E_rd = 3;
    cycle();
    for (int i = 1; i <= 10; i++) begin
      hif.div_done = (i == 10);
      cycle();
    end
    hif.div_done = 0;
    cycle();
    zero_inputs();
    hif.div_done = 1;
    cycle();
    hif.div_done = 0;
    cycle();

    // reset mid-divide, no relaunch without a divide in Execute, then relaunch
    hif.E_is_div = 1; hif.E_RegWrite = 1;
    repeat (4) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    zero_inputs();
    rst = 1'b0;
    cycle();
    hif.E_is_div = 1; hif.E_RegWrite = 1;
    cycle();

    // withhold div_done well past the watchdog limit
    for (int i = 0; i < DIV_TO + 6; i++) cycle();
    zero_inputs();
    repeat (3) cycle();

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      hif.D_ra = 5'($urandom_range(0, 3));
      hif.D_rb = 5'($urandom_range(0, 3));
      hif.E_ra = 5'($urandom_range(0, 3));
      hif.E_rb = 5'($urandom_range(0, 3));
      hif.E_rd = 5'($urandom_range(0, 3));
      hif.M_rd = 5'($urandom_range(0, 3));
      hif.W_rd = 5'($urandom_range(0, 3));
      hif.E_RegWrite   = ($urandom_range(0, 3) != 0);
      hif.M_RegWrite   = 1'($urandom_range(0, 1));
      hif.W_RegWrite   = 1'($urandom_range(0, 1));
      hif.E_result_src = 2'($urandom_range(0, 3));
      hif.E_is_div     = ($urandom_range(0, 7) == 0);
      hif.E_PCSrc      = ($urandom_range(0, 5) == 0);
      hif.div_done     = ($urandom_range(0, 5) == 0);
      rst              = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    zero_inputs();
    cycle();

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
